// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_controller_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_MRET_RD  = 2'd3
  } trap_state_t;

  localparam logic [XLEN-1:0] EXC_CAUSE_INSTR_MISALIGNED = 32'd0;
  localparam logic [XLEN-1:0] EXC_CAUSE_ILLEGAL          = 32'd2;
  localparam logic [XLEN-1:0] EXC_CAUSE_BREAKPOINT       = 32'd3;
  localparam logic [XLEN-1:0] EXC_CAUSE_LOAD_MISALIGNED  = 32'd4;
  localparam logic [XLEN-1:0] EXC_CAUSE_STORE_MISALIGNED = 32'd6;
  localparam logic [XLEN-1:0] EXC_CAUSE_ECALL_M          = 32'd11;
  localparam logic [XLEN-1:0] IRQ_CAUSE_MTIMER           = 32'h8000_0007;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] info;
    logic [XLEN-1:0] pc;
  } trap_req_t;
endpackage

// File: rtl/trap_priority_enc.sv
// Picks the highest-priority trap source at the instruction boundary and
// builds its mcause/mtval/mepc triple.
module trap_priority_enc
  import trap_controller_pkg::*;
(
  input  logic            i_timer_irq,
  input  logic            i_illegal,
  input  logic            i_instr_misaligned,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_store_misaligned,
  input  logic            i_load_misaligned,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_mem_addr,
  output logic            o_valid,
  output trap_req_t       o_req
);
  always_comb begin
    o_valid      = 1'b1;
    o_req.cause  = '0;
    o_req.info   = '0;
    o_req.pc     = i_pc;
    if (i_timer_irq) begin
      o_req.cause = IRQ_CAUSE_MTIMER;
    end else if (i_illegal) begin
      o_req.cause = EXC_CAUSE_ILLEGAL;
      o_req.info  = i_instr;
    end else if (i_instr_misaligned) begin
      o_req.cause = EXC_CAUSE_INSTR_MISALIGNED;
      o_req.info  = i_mem_addr;
    end else if (i_ecall) begin
      o_req.cause = EXC_CAUSE_ECALL_M;
    end else if (i_ebreak) begin
      o_req.cause = EXC_CAUSE_BREAKPOINT;
      o_req.info  = i_pc;
    end else if (i_store_misaligned) begin
      o_req.cause = EXC_CAUSE_STORE_MISALIGNED;
      o_req.info  = i_mem_addr;
    end else if (i_load_misaligned) begin
      o_req.cause = EXC_CAUSE_LOAD_MISALIGNED;
      o_req.info  = i_mem_addr;
    end else begin
      o_valid = 1'b0;
    end
  end
endmodule

// File: rtl/trap_controller.sv
// Trap sequencer: stalls/flushes the core, strobes trap entry into the CSR
// unit and redirects fetch to mtvec (trap) or mepc (MRET).
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter bit VECTORED_IRQ = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            illegal_instr_i,
  input  logic            instr_misaligned_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            load_misaligned_i,
  input  logic            store_misaligned_i,
  input  logic            mret_i,
  input  logic            timer_irq_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            jumping_to_mtvec_o,
  output logic [XLEN-1:0] exc_cause_o,
  output logic [XLEN-1:0] trap_info_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);
  trap_state_t     r_state, w_state_nxt;
  trap_req_t       r_req, w_req;
  logic            w_enc_valid, w_take_trap, w_take_mret;
  logic [XLEN-1:0] w_trap_target;

  trap_priority_enc u_prio (
    .i_timer_irq        (timer_irq_i),
    .i_illegal          (illegal_instr_i),
    .i_instr_misaligned (instr_misaligned_i),
    .i_ecall            (ecall_i),
    .i_ebreak           (ebreak_i),
    .i_store_misaligned (store_misaligned_i),
    .i_load_misaligned  (load_misaligned_i),
    .i_pc               (pc_i),
    .i_instr            (instr_i),
    .i_mem_addr         (mem_addr_i),
    .o_valid            (w_enc_valid),
    .o_req              (w_req)
  );

  assign w_take_trap = instr_valid_i & w_enc_valid;
  assign w_take_mret = instr_valid_i & mret_i & ~w_enc_valid;

  // Only interrupts are vectored; synchronous exceptions always go to the base.
  assign w_trap_target = (VECTORED_IRQ && r_req.cause[XLEN-1])
                       ? mtvec_i + {{(XLEN-7){1'b0}}, r_req.cause[4:0], 2'b00}
                       : mtvec_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_take_trap) r_req <= w_req;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    jumping_to_mtvec_o = 1'b0;
    exc_cause_o        = '0;
    trap_info_o        = '0;
    trap_pc_o          = '0;
    stall_o            = 1'b0;
    flush_o            = 1'b0;
    redirect_o         = 1'b0;
    redirect_pc_o      = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_take_trap) begin
          stall_o     = 1'b1;
          w_state_nxt = ST_TRAP;
        end else if (w_take_mret) begin
          stall_o     = 1'b1;
          w_state_nxt = ST_MRET_RD;
        end
      end
      ST_TRAP: begin
        jumping_to_mtvec_o = 1'b1;
        stall_o            = 1'b1;
        flush_o            = 1'b1;
        exc_cause_o        = r_req.cause;
        trap_info_o        = r_req.info;
        trap_pc_o          = r_req.pc;
        w_state_nxt        = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_o    = 1'b1;
        stall_o       = 1'b1;
        redirect_pc_o = w_trap_target;
        w_state_nxt   = ST_IDLE;
      end
      ST_MRET_RD: begin
        redirect_o    = 1'b1;
        flush_o       = 1'b1;
        redirect_pc_o = mepc_i;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Reset suppresses every output so a pending redirect can never escape.
    if (rst) begin
      jumping_to_mtvec_o = 1'b0;
      exc_cause_o        = '0;
      trap_info_o        = '0;
      trap_pc_o          = '0;
      stall_o            = 1'b0;
      flush_o            = 1'b0;
      redirect_o         = 1'b0;
      redirect_pc_o      = '0;
    end
  end
endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Trap sequencer that sits directly upstream of the machine CSR unit.
- Collects the core's synchronous exception flags, the MRET indication and the CSR unit's timer-interrupt request at the instruction boundary, and prioritises them.
- Drives the CSR unit's trap-entry strobe, cause, trap info and faulting PC.
- Stalls and flushes the core, then redirects fetch to mtvec (trap) or mepc (MRET).

Parameters:
- VECTORED_IRQ, 0, when 1 the interrupt redirect PC is mtvec_i + 4*cause[4:0]; when 0 it is mtvec_i.
- XLEN, 32, datapath width (from shared package).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous and active-high
- instr_valid_i  in  1  instruction at boundary this cycle; flags below qualified by it
- pc_i  in  32  PC of boundary instruction
- instr_i  in  32  raw instruction word (tval for illegal)
- mem_addr_i  in  32  effective load/store/branch target address
- illegal_instr_i, instr_misaligned_i, ecall_i, ebreak_i, load_misaligned_i, store_misaligned_i  in  1 each  synchronous exception flags
- mret_i  in  1  boundary instruction is MRET
- timer_irq_i  in  1  level timer interrupt request from CSR unit (enable-gated)
- mtvec_i  in  32  current mtvec from CSR unit
- mepc_i  in  32  current mepc from CSR unit
- jumping_to_mtvec_o  out  1  one-cycle trap-entry strobe to CSR unit
- exc_cause_o  out  32  mcause value
- trap_info_o  out  32  mtval value
- trap_pc_o  out  32  PC to save into mepc
- stall_o  out  1  hold core, no retire
- flush_o  out  1  kill in-flight instructions
- redirect_o  out  1  load fetch PC with redirect_pc_o
- redirect_pc_o  out  32  new fetch PC

Behaviour:
- States: IDLE, TRAP, REDIRECT, MRET_RD.
- Reset: state IDLE; all outputs 0; registered cause/info/pc 0.
  - A reset asserted in any state returns to IDLE next edge with no redirect issued.
- IDLE, trap detection
  - Trap taken when instr_valid_i=1 and (timer_irq_i=1 or any exception flag=1).
  - On detection: stall_o=1 combinationally in the same cycle (N); next state TRAP.
  - Cause, info and pc are registered at edge N.
- Priority, highest first:
  - timer interrupt: cause 0x8000_0007, info 0
  - illegal: cause 2, info instr_i
  - instr misaligned: cause 0, info mem_addr_i
  - ecall: cause 11, info 0
  - ebreak: cause 3, info pc_i
  - store misaligned: cause 6, info mem_addr_i
  - load misaligned: cause 4, info mem_addr_i
- trap_pc_o = pc_i of the boundary instruction for every trap. For interrupts the instruction is not executed.
- TRAP, cycle N+1:
  - jumping_to_mtvec_o=1, stall_o=1, flush_o=1.
  - exc_cause_o, trap_info_o and trap_pc_o hold the registered values and stay valid only while the strobe is high; otherwise 0.
  - Next state REDIRECT.
- REDIRECT, cycle N+2:
  - redirect_o=1, stall_o=1.
  - redirect_pc_o = mtvec_i, or mtvec_i+4*cause[4:0] when VECTORED_IRQ=1 and cause bit31=1.
  - Next state IDLE.
- MRET:
  - In IDLE, instr_valid_i & mret_i with no trap condition gives stall_o=1 in cycle N; next state MRET_RD.
  - MRET_RD: redirect_o=1, flush_o=1, redirect_pc_o=mepc_i; next state IDLE.
  - MRET together with a pending interrupt: the interrupt wins and the MRET is not executed.
- Flags, mret_i and timer_irq_i are ignored outside IDLE.
  - An interrupt that drops before a boundary is never taken (level-sensitive, no latch).
- instr_valid_i=0 in IDLE: no action, even with timer_irq_i high.
- Back-to-back: a new trap may be detected in the first IDLE cycle after REDIRECT. Minimum trap-to-trap spacing is 3 cycles.
- redirect_pc_o is 0 when redirect_o=0.

Decomposition:
- Shared package contents:
  - trap_state_t enum
  - EXC_CAUSE_* constants (0, 2, 3, 4, 6, 11)
  - IRQ_CAUSE_MTIMER = 32'h8000_0007
  - trap_req_t struct {cause, info, pc}
- One sub-module, trap_priority_enc: combinational.
  - Flags + irq + pc/instr/addr in; valid + trap_req_t out.
  - The FSM stays in trap_controller.

Test Plan:
- illegal_instr_i=1, instr_valid_i=1, pc_i=0x100, instr_i=0xFFFF_FFFF -> N: stall=1; N+1: strobe=1, cause=2, info=0xFFFF_FFFF, trap_pc=0x100; N+2: redirect=1, pc=mtvec_i (0x200).
- timer_irq_i=1 and ecall_i=1 same boundary, VECTORED_IRQ=1, mtvec_i=0x400 -> cause=0x8000_0007, info=0; redirect_pc=0x41C.
- mret_i=1, mepc_i=0x1234 -> N+1: redirect=1, flush=1, pc=0x1234; jumping_to_mtvec_o never asserts.
- timer_irq_i=1 with instr_valid_i=0 for 5 cycles, dropped before the next boundary -> no trap, stall=0 throughout.
- load_misaligned_i+store_misaligned_i, mem_addr_i=0x1003 -> cause=6, info=0x1003; a second ecall arriving during TRAP is ignored; a new ecall in the first IDLE cycle after REDIRECT is taken (cause 11).
- rst=1 during TRAP -> next cycle all outputs 0, state IDLE, no redirect.
